voltmeter_digit_renderer: RTL and testbench
===========================================

Name: voltmeter_digit_renderer

Overview:
- Pixel source that sits directly upstream of the VGA sync/timing stage.
- Converts a 12-bit millivolt reading to BCD with an iterative double-dabble FSM.
- Latches the result into a frame-stable shadow register during vertical blanking, so a frame never shows two different readings.
- Renders four 7-segment glyphs ("D.DDD") plus a decimal point. The colour is returned to the sync stage's rgb_in from that stage's h/v counters.

Parameters:
- X0, 200, left pixel column of digit 0 cell
- Y0, 200, top pixel row of all digit cells
- DIG_W, 40, digit cell width in pixels
- DIG_H, 80, digit cell height in pixels (even)
- SEG_T, 8, segment thickness in pixels
- GAP, 24, horizontal spacing between cells (must be >= 2*SEG_T)
- V_DISPLAY, 480, visible lines; shadow update occurs at v == V_DISPLAY
- FG, 12'hFFF, lit-segment colour
- BG, 12'h000, background colour
- OVR_MV, 3300, over-range threshold in mV (used only with the optional feature)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h  in  10  current column from the sync stage
- v  in  10  current row from the sync stage
- sample_valid  in  1  one-cycle strobe; sample_mv is valid
- sample_mv  in  12  reading in millivolts, 0..4095
- conv_busy  out  1  double-dabble conversion in progress
- rgb  out  12  registered pixel colour, feeds rgb_in of the sync stage

Behaviour:
- Reset: all of the following clear asynchronously.
  - FSM goes to IDLE.
  - conv_busy=0, rgb=BG.
  - Pending flag cleared.
  - Working BCD, result BCD and shadow BCD = 0, so the display reads 0.000.
- FSM states and transitions:
  - IDLE: on sample_valid, load the shift register = {16'b0, sample_mv}, set iter=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble >= 5, then shift left 1; iter++. After the 12th shift go to DONE.
  - DONE: copy the BCD to the result register, set result_new=1, go to IDLE if nothing is pending. If pending, start that sample next cycle.
- conv_busy = 1 in SHIFT and DONE. Latency from sample_valid to result valid: 13 cycles.
- sample_valid while busy: store the value in a pending register; the newest pending value wins.
  - Exactly one follow-up conversion runs after DONE.
  - Earlier pending values are dropped silently.
- Shadow update: on the cycle with h==0 and v==V_DISPLAY, if result_new, shadow <= result and result_new <= 0.
  - If DONE occurs in that same cycle, the new result is not taken; it waits for the next frame.
- Digit cell i (0..3) spans columns [X0+i*(DIG_W+GAP), +DIG_W) and rows [Y0, Y0+DIG_H). Cell-local coordinates are (x,y).
- Segment rectangles, half-open ranges, with M=(DIG_H-SEG_T)/2:
  - a: y in [0,SEG_T), x in [SEG_T, DIG_W-SEG_T)
  - g: y in [M, M+SEG_T), x as a
  - d: y in [DIG_H-SEG_T, DIG_H), x as a
  - f: x in [0,SEG_T), y in [0, DIG_H/2)
  - b: x in [DIG_W-SEG_T, DIG_W), y in [0, DIG_H/2)
  - e: x as f, y in [DIG_H/2, DIG_H)
  - c: x as b, y in [DIG_H/2, DIG_H)
- Decimal point: always lit. Square at columns [X0+DIG_W+(GAP-SEG_T)/2, +SEG_T) and rows [Y0+DIG_H-SEG_T, Y0+DIG_H).
- Segment decode: standard 7-segment patterns for 0..9; nibbles >9 blank (cannot occur). Digit 0 is the thousands digit; leading zeros are displayed.
- Output:
  - rgb <= FG if (h,v) lies in a lit segment or the DP, else BG.
  - One-cycle registered latency; glyphs appear shifted right by one pixel, which is accepted.
  - Blanking outside the visible area is the sync stage's job.
- Arithmetic: unsigned only. Coordinate compares use 11-bit intermediates, so no wrap occurs for cells near column 639.

Optional Feature:
- Macro: VOLTMETER_OVERRANGE_EN.
- When defined:
  - The shadow register also latches an over flag = (converted value > OVR_MV).
  - Lit pixels use 12'hF00 while over=1.
  - over resets to 0.
- When undefined: no flag register; lit pixels are always FG.

Test Plan:
- Reset -> rgb=BG, conv_busy=0. Then scan h=220,v=203 (digit 0 seg a) -> FG, because 0 lights a.
- sample_mv=3300 at cycle 0 -> conv_busy high cycles 1..13, result BCD 3,3,0,0. Display is unchanged until h=0,v=480; in the next frame h=220,v=203 -> FG, h=266,v=220 (digit 1 seg f, "3") -> BG, h=340,v=240 (digit 2 seg g, "0") -> BG, h=330,v=220 (digit 2 seg f) -> FG.
- Strobe 1000, then 2000 and 4095 during busy -> exactly two conversions (1000, then 4095); after two frame boundaries the shadow holds 4,0,9,5.
- Conversion DONE coincident with h=0,v=480 -> shadow unchanged that frame, updated at the next boundary.
- rst_n low mid-SHIFT (iter=6) -> conv_busy=0 and rgb=BG immediately; shadow reads 0.000; a new sample after release converts correctly.
- With VOLTMETER_OVERRANGE_EN: 3301 -> lit pixels 12'hF00 after the boundary; 3300 -> FG.

Source files
------------

// File: rtl/voltmeter_digit_renderer.sv
// Voltmeter pixel source: converts a millivolt reading to BCD with a
// double-dabble FSM, holds it frame-stable and renders "D.DDD" as 7-segment
// glyphs for the downstream VGA sync stage.
// Optional macro VOLTMETER_OVERRANGE_EN: lit pixels turn red when the
// displayed reading exceeds OVR_MV.
module voltmeter_digit_renderer #(
   parameter int unsigned X0        = 200,
   parameter int unsigned Y0        = 200,
   parameter int unsigned DIG_W     = 40,
   parameter int unsigned DIG_H     = 80,
   parameter int unsigned SEG_T     = 8,
   parameter int unsigned GAP       = 24,
   parameter int unsigned V_DISPLAY = 480,
   parameter logic [11:0] FG        = 12'hFFF,
   parameter logic [11:0] BG        = 12'h000
`ifdef VOLTMETER_OVERRANGE_EN
   , parameter int unsigned OVR_MV  = 3300
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  h,
   input  logic [9:0]  v,
   input  logic        sample_valid,
   input  logic [11:0] sample_mv,
   output logic        conv_busy,
   output logic [11:0] rgb
);

   localparam int unsigned BIN_W = 12;
   localparam int unsigned BCD_W = 16;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CRD_W = 11;

   localparam logic [CRD_W-1:0] T_C    = CRD_W'(SEG_T);
   localparam logic [CRD_W-1:0] W_C    = CRD_W'(DIG_W);
   localparam logic [CRD_W-1:0] H_C    = CRD_W'(DIG_H);
   localparam logic [CRD_W-1:0] HALF_C = CRD_W'(DIG_H / 2);
   localparam logic [CRD_W-1:0] MID_C  = CRD_W'((DIG_H - SEG_T) / 2);
   localparam logic [CRD_W-1:0] Y0_C   = CRD_W'(Y0);
   localparam logic [CRD_W-1:0] DP_X_C = CRD_W'(X0 + DIG_W + (GAP - SEG_T) / 2);
   localparam logic [CRD_W-1:0] DP_Y_C = CRD_W'(Y0 + DIG_H - SEG_T);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [SR_W-1:0]    sr_q;
   logic [3:0]         iter_q;
   logic               pend_q;
   logic [BIN_W-1:0]   pend_mv_q;
   logic [BCD_W-1:0]   result_q;
   logic               result_new_q;
   logic [BCD_W-1:0]   shadow_q;
   logic               frame_edge_c;
`ifdef VOLTMETER_OVERRANGE_EN
   logic [BIN_W-1:0]   cur_mv_q;
   logic               res_over_q;
   logic               over_q;
`endif

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
   function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
      logic [SR_W-1:0] a;
      a = s;
      for (int k = 0; k < 4; k++) begin
         if (a[BIN_W+4*k +: 4] >= 4'd5)
            a[BIN_W+4*k +: 4] = a[BIN_W+4*k +: 4] + 4'd3;
      end
      return {a[SR_W-2:0], 1'b0};
   endfunction

   // Segment pattern {g,f,e,d,c,b,a} for a BCD digit; non-decimal codes blank
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // True when cell-local (x,y) falls inside any lit segment rectangle
   function automatic logic seg_hit(input logic [6:0] s, input logic [CRD_W-1:0] x,
                                    input logic [CRD_W-1:0] y);
      logic xm, xl, xr, top, bot;
      xm  = (x >= T_C) && (x < W_C - T_C);
      xl  = (x < T_C);
      xr  = (x >= W_C - T_C);
      top = (y < HALF_C);
      bot = (y >= HALF_C);
      return (s[0] && xm && (y < T_C)) ||
             (s[6] && xm && (y >= MID_C) && (y < MID_C + T_C)) ||
             (s[3] && xm && (y >= H_C - T_C)) ||
             (s[5] && xl && top) ||
             (s[1] && xr && top) ||
             (s[4] && xl && bot) ||
             (s[2] && xr && bot);
   endfunction

   assign frame_edge_c = (h == 10'd0) && (v == 10'(V_DISPLAY));

   // Conversion FSM, pending-sample capture and frame-boundary shadow latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sr_q         <= '0;
         iter_q       <= '0;
         pend_q       <= 1'b0;
         pend_mv_q    <= '0;
         result_q     <= '0;
         result_new_q <= 1'b0;
         shadow_q     <= '0;
         conv_busy    <= 1'b0;
`ifdef VOLTMETER_OVERRANGE_EN
         cur_mv_q     <= '0;
         res_over_q   <= 1'b0;
         over_q       <= 1'b0;
`endif
      end else begin
         // A DONE in this same cycle sets result_new again below, so it waits a frame
         if (frame_edge_c && result_new_q) begin
            shadow_q     <= result_q;
            result_new_q <= 1'b0;
`ifdef VOLTMETER_OVERRANGE_EN
            over_q       <= res_over_q;
`endif
         end
         case (state_q)
            S_IDLE: begin
               if (sample_valid) begin
                  sr_q      <= {{BCD_W{1'b0}}, sample_mv};
                  iter_q    <= '0;
                  state_q   <= S_SHIFT;
                  conv_busy <= 1'b1;
`ifdef VOLTMETER_OVERRANGE_EN
                  cur_mv_q  <= sample_mv;
`endif
               end
            end
            S_SHIFT: begin
               sr_q   <= dd_step(sr_q);
               iter_q <= iter_q + 4'd1;
               if (iter_q == 4'(BIN_W - 1))
                  state_q <= S_DONE;
               if (sample_valid) begin
                  pend_q    <= 1'b1;
                  pend_mv_q <= sample_mv;
               end
            end
            S_DONE: begin
               result_q     <= sr_q[SR_W-1:BIN_W];
               result_new_q <= 1'b1;
`ifdef VOLTMETER_OVERRANGE_EN
               res_over_q   <= ({1'b0, cur_mv_q} > 13'(OVR_MV));
`endif
               // Newest sample wins: a strobe here supersedes the stored one
               if (sample_valid || pend_q) begin
                  sr_q    <= {{BCD_W{1'b0}}, (sample_valid ? sample_mv : pend_mv_q)};
                  iter_q  <= '0;
                  pend_q  <= 1'b0;
                  state_q <= S_SHIFT;
`ifdef VOLTMETER_OVERRANGE_EN
                  cur_mv_q <= sample_valid ? sample_mv : pend_mv_q;
`endif
               end else begin
                  state_q   <= S_IDLE;
                  conv_busy <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               conv_busy <= 1'b0;
            end
         endcase
      end
   end

   logic [CRD_W-1:0] hx_c;
   logic [CRD_W-1:0] vy_c;
   logic [CRD_W-1:0] cell_x_c;
   logic [3:0]       digit_c;
   logic             lit_c;
   logic [11:0]      fg_c;

   // Hit-test the current pixel against the four glyphs and the decimal point
   always_comb begin
      hx_c     = {1'b0, h};
      vy_c     = {1'b0, v};
      cell_x_c = '0;
      digit_c  = '0;
      lit_c    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cell_x_c = CRD_W'(X0 + 32'(i) * (DIG_W + GAP));
         digit_c  = shadow_q[BCD_W-1-4*i -: 4];
         if ((hx_c >= cell_x_c) && (hx_c < cell_x_c + W_C) &&
             (vy_c >= Y0_C) && (vy_c < Y0_C + H_C))
            lit_c = lit_c | seg_hit(seg_decode(digit_c), hx_c - cell_x_c, vy_c - Y0_C);
      end
      if ((hx_c >= DP_X_C) && (hx_c < DP_X_C + T_C) &&
          (vy_c >= DP_Y_C) && (vy_c < DP_Y_C + T_C))
         lit_c = 1'b1;
`ifdef VOLTMETER_OVERRANGE_EN
      fg_c = over_q ? 12'hF00 : FG;
`else
      fg_c = FG;
`endif
   end

   // Registered pixel colour toward the sync stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb <= BG;
      else        rgb <= lit_c ? fg_c : BG;
   end

endmodule

// File: tb/tb_voltmeter_digit_renderer.sv
// Self-checking bench for voltmeter_digit_renderer: directed scenarios plus
// random strobes/pixels checked against a cycle-level behavioural model.
module tb_voltmeter_digit_renderer;

   localparam int X0 = 200, Y0 = 200, DIG_W = 40, DIG_H = 80, SEG_T = 8, GAP = 24;
   localparam int V_DISPLAY = 480;
   localparam int MID = (DIG_H - SEG_T) / 2;
   localparam logic [11:0] FG = 12'hFFF, BG = 12'h000, RED = 12'hF00;

   logic        clk;
   logic        rst_n;
   logic [9:0]  h;
   logic [9:0]  v;
   logic        sample_valid;
   logic [11:0] sample_mv;
   logic        conv_busy;
   logic [11:0] rgb;

   voltmeter_digit_renderer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .h            (h),
      .v            (v),
      .sample_valid (sample_valid),
      .sample_mv    (sample_mv),
      .conv_busy    (conv_busy),
      .rgb          (rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   // Model state: conversion in flight, pending sample, result and shadow values
   bit m_busy, m_pend, m_new, m_over;
   int m_left, m_cur, m_pend_val, m_result, m_shadow;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [11:0] model_pixel(input int hh, input int vv,
                                                input int val, input bit over);
      bit lit;
      int x, y, dig, div;
      string s;
      byte c;
      lit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         div = (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1;
         dig = (val / div) % 10;
         x = hh - (X0 + i * (DIG_W + GAP));
         y = vv - Y0;
         if (x >= 0 && x < DIG_W && y >= 0 && y < DIG_H) begin
            s = SEGS[dig];
            for (int k = 0; k < s.len(); k++) begin
               c = s[k];
               case (c)
                  "a": if (y < SEG_T && x >= SEG_T && x < DIG_W - SEG_T) lit = 1'b1;
                  "g": if (y >= MID && y < MID + SEG_T && x >= SEG_T && x < DIG_W - SEG_T) lit = 1'b1;
                  "d": if (y >= DIG_H - SEG_T && x >= SEG_T && x < DIG_W - SEG_T) lit = 1'b1;
                  "f": if (x < SEG_T && y < DIG_H / 2) lit = 1'b1;
                  "b": if (x >= DIG_W - SEG_T && y < DIG_H / 2) lit = 1'b1;
                  "e": if (x < SEG_T && y >= DIG_H / 2) lit = 1'b1;
                  "c": if (x >= DIG_W - SEG_T && y >= DIG_H / 2) lit = 1'b1;
                  default: ;
               endcase
            end
         end
      end
      if (hh >= X0 + DIG_W + (GAP - SEG_T) / 2 && hh < X0 + DIG_W + (GAP - SEG_T) / 2 + SEG_T &&
          vv >= Y0 + DIG_H - SEG_T && vv < Y0 + DIG_H)
         lit = 1'b1;
      return lit ? (over ? RED : FG) : BG;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_pend = 0; m_new = 0; m_over = 0;
      m_left = 0; m_cur = 0; m_pend_val = 0; m_result = 0; m_shadow = 0;
   endtask

   // One clock of the behavioural model: 13 busy cycles per conversion, the
   // last of which publishes the result; newest busy-time strobe queued.
   task automatic model_step(input bit sv, input int mv, input int hh, input int vv);
      if (hh == 0 && vv == V_DISPLAY && m_new) begin
         m_shadow = m_result;
         m_new    = 0;
`ifdef VOLTMETER_OVERRANGE_EN
         m_over   = (m_result > 3300);
`endif
      end
      if (!m_busy) begin
         if (sv) begin m_busy = 1; m_cur = mv; m_left = 12; end
      end else if (m_left == 0) begin
         m_result = m_cur;
         m_new    = 1;
         if (sv) begin m_cur = mv; m_left = 12; m_pend = 0; end
         else if (m_pend) begin m_cur = m_pend_val; m_left = 12; m_pend = 0; end
         else m_busy = 0;
      end else begin
         m_left--;
         if (sv) begin m_pend = 1; m_pend_val = mv; end
      end
   endtask

   task automatic tick(input bit sv, input int mv, input int hh, input int vv);
      logic [11:0] exp_rgb;
      sample_valid = sv;
      sample_mv    = 12'(mv);
      h            = 10'(hh);
      v            = 10'(vv);
      exp_rgb = model_pixel(hh, vv, m_shadow, m_over);
      @(posedge clk);
      model_step(sv, mv, hh, vv);
      #1;
      check("rgb", 32'(rgb), 32'(exp_rgb));
      check("busy", 32'(conv_busy), 32'(m_busy));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 100, 100);
   endtask

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; sample_mv = '0; h = '0; v = '0;
      model_reset();
      #12;
      check("reset_rgb", 32'(rgb), 32'(BG));
      check("reset_busy", 32'(conv_busy), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Reset display reads 0.000
      tick(1'b0, 0, 220, 203);
      check("zero_d0_a", 32'(rgb), 32'(FG));

      // 3300: busy for 13 cycles, display changes only after the frame edge
      tick(1'b1, 3300, 100, 100);
      idle(13);
      tick(1'b0, 0, 266, 220);
      check("preframe_d1_f", 32'(rgb), 32'(FG));
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 220, 203);
      check("v3300_d0_a", 32'(rgb), 32'(FG));
      tick(1'b0, 0, 266, 220);
      check("v3300_d1_f", 32'(rgb), 32'(BG));
      tick(1'b0, 0, 340, 240);
      check("v3300_d2_g", 32'(rgb), 32'(BG));
      tick(1'b0, 0, 330, 220);
      check("v3300_d2_f", 32'(rgb), 32'(FG));

      // 1000, then 2000 and 4095 while busy: 4095 is the only follow-up
      tick(1'b1, 1000, 100, 100);
      idle(2);
      tick(1'b1, 2000, 100, 100);
      idle(3);
      tick(1'b1, 4095, 100, 100);
      idle(30);
      tick(1'b0, 0, 0, V_DISPLAY);
      idle(5);
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 220, 203);
      check("v4095_d0_a", 32'(rgb), 32'(BG));
      tick(1'b0, 0, 202, 220);
      check("v4095_d0_f", 32'(rgb), 32'(FG));
      tick(1'b0, 0, 340, 240);
      check("v4095_d2_g", 32'(rgb), 32'(FG));
      tick(1'b0, 0, 426, 220);
      check("v4095_d3_b", 32'(rgb), 32'(BG));
      tick(1'b0, 0, 250, 275);
      check("dp_lit", 32'(rgb), 32'(FG));

      // DONE coincides with the frame edge: update deferred one frame
      tick(1'b1, 1234, 100, 100);
      idle(12);
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 202, 220);
      check("coinc_hold", 32'(rgb), 32'(FG));
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 202, 220);
      check("coinc_next", 32'(rgb), 32'(BG));

      // Reset mid-conversion
      tick(1'b1, 2222, 100, 100);
      idle(6);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(conv_busy), 32'd0);
      check("midrst_rgb", 32'(rgb), 32'(BG));
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      tick(1'b0, 0, 202, 220);
      check("midrst_zero", 32'(rgb), 32'(FG));
      tick(1'b1, 789, 100, 100);
      idle(14);
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 266, 220);
      check("v789_d1_f", 32'(rgb), 32'(BG));
      tick(1'b0, 0, 284, 203);
      check("v789_d1_a", 32'(rgb), 32'(FG));

`ifdef VOLTMETER_OVERRANGE_EN
      tick(1'b1, 3301, 100, 100);
      idle(14);
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 220, 203);
      check("over_red", 32'(rgb), 32'(RED));
      tick(1'b1, 3300, 100, 100);
      idle(14);
      tick(1'b0, 0, 0, V_DISPLAY);
      tick(1'b0, 0, 220, 203);
      check("over_edge_fg", 32'(rgb), 32'(FG));
`endif

      // Random strobes, readings and pixel positions
      for (int n = 0; n < 3000; n++) begin
         bit sv;
         int hh, vv;
         sv = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) begin
            hh = 0; vv = V_DISPLAY;
         end else begin
            hh = int'($urandom_range(190, 469));
            vv = int'($urandom_range(190, 289));
         end
         tick(sv, int'($urandom_range(0, 4095)), hh, vv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
